// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of im_loader.
// master is the loader side, slave the stream source / IM side.
interface im_loader_if;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        im_we;
   logic [31:0] im_addr;
   logic [31:0] im_wdata;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, im_we, im_addr, im_wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, im_we, im_addr, im_wdata
   );
endinterface

// File: rtl/im_loader.sv
// Assembles a big-endian byte stream (4-byte word count N, then N words) into IM writes
// and holds the CPU until the image is complete. Optional trailing checksum: IM_LOADER_CHECKSUM_EN.
module im_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
   parameter int          DEPTH     = 4096,
   parameter int          CNT_W     = 13
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   im_loader_if.master      bus,
   output logic             cpu_hold,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t             state_reg, state_next;
   logic [1:0]         lane_reg;
   logic [23:0]        shift_reg;
   logic [CNT_W-1:0]   n_reg;
   logic [CNT_W-1:0]   word_cnt_reg;
   logic               im_we_reg;
   logic [31:0]        im_addr_reg;
   logic [31:0]        im_wdata_reg;
`ifdef IM_LOADER_CHECKSUM_EN
   logic [31:0]        sum_reg;
`endif

   logic               ready;
   logic               accept;
   logic               last_lane;
   logic               start_load;
   logic [31:0]        assembled;
   state_t             end_state;

   // Stop accepting once all N words are in; the DATA->DONE step waits for the final write cycle.
   assign ready = (state_reg == S_HDR)
`ifdef IM_LOADER_CHECKSUM_EN
                || (state_reg == S_CHK)
`endif
                || ((state_reg == S_DATA) && (word_cnt_reg != n_reg));

   assign accept     = bus.byte_valid && ready;
   assign last_lane  = (lane_reg == 2'd3);
   assign assembled  = {shift_reg, bus.byte_data};
   assign start_load = start && ((state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERR));

`ifdef IM_LOADER_CHECKSUM_EN
   assign end_state = S_CHK;
`else
   assign end_state = S_DONE;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_next = S_HDR;
         end
         S_HDR: begin
            if (accept && last_lane) begin
               if (assembled == 32'd0)
                  state_next = end_state;
               else if (assembled > 32'(DEPTH))
                  state_next = S_ERR;
               else
                  state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (im_we_reg && (word_cnt_reg == n_reg)) state_next = end_state;
         end
`ifdef IM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept && last_lane)
               state_next = (assembled == sum_reg) ? S_DONE : S_ERR;
         end
`endif
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_reg     <= 2'd0;
         shift_reg    <= 24'd0;
         n_reg        <= '0;
         word_cnt_reg <= '0;
         im_we_reg    <= 1'b0;
         im_addr_reg  <= BASE_ADDR;
         im_wdata_reg <= 32'd0;
`ifdef IM_LOADER_CHECKSUM_EN
         sum_reg      <= 32'd0;
`endif
      end else begin
         im_we_reg <= 1'b0;
         if (start_load) begin
            lane_reg     <= 2'd0;
            word_cnt_reg <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            sum_reg      <= 32'd0;
`endif
         end else if (accept) begin
            lane_reg  <= lane_reg + 2'd1;
            shift_reg <= assembled[23:0];
            if (last_lane && (state_reg == S_HDR)) begin
               n_reg <= assembled[CNT_W-1:0];
            end
            // Address uses the pre-increment count so word k lands at BASE_ADDR + 4*k.
            if (last_lane && (state_reg == S_DATA)) begin
               im_we_reg    <= 1'b1;
               im_wdata_reg <= assembled;
               im_addr_reg  <= BASE_ADDR + {{(30-CNT_W){1'b0}}, word_cnt_reg, 2'b00};
               word_cnt_reg <= word_cnt_reg + 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
               sum_reg      <= sum_reg + assembled;
`endif
            end
         end
      end
   end

   assign bus.byte_ready = ready;
   assign bus.im_we      = im_we_reg;
   assign bus.im_addr    = im_addr_reg;
   assign bus.im_wdata   = im_wdata_reg;
   assign word_cnt       = word_cnt_reg;
   assign done           = (state_reg == S_DONE);
   assign err            = (state_reg == S_ERR);
   assign cpu_hold       = (state_reg != S_DONE);

endmodule

// File: tb/tb_im_loader.sv
// Directed vector table for im_loader plus hand-written sequences for a full-depth load
// (and, when IM_LOADER_CHECKSUM_EN is defined, the checksum accept/reject paths).
module tb_im_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        cpu_hold, done, err;
   logic [12:0] word_cnt;
   int          nvec = 0;
   int          nmiss = 0;

   im_loader_if bus();

   im_loader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r, s, v;
      logic [7:0]  d;
      logic        rdy, we;
      logic [31:0] addr, wdata;
      logic        hold, dn, er;
      logic [12:0] cnt;
   } vec_t;

   vec_t vecs[$];

   localparam logic [31:0] W1 = 32'h3C01_8765;
   localparam logic [31:0] W2 = 32'h3421_4321;
   localparam logic [31:0] WN = 32'h1234_5678;
   localparam logic [31:0] WR = 32'hDEAD_BEEF;

   task automatic add(input logic r, s, v, input logic [7:0] d, input logic rdy, we,
                      input logic [31:0] a, wd, input logic h, dn, er, input int c);
      vec_t x;
      x.r = r; x.s = s; x.v = v; x.d = d; x.rdy = rdy; x.we = we; x.addr = a; x.wdata = wd;
      x.hold = h; x.dn = dn; x.er = er; x.cnt = 13'(c);
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      nvec++;
      if (act !== exp) begin
         nmiss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic v, input logic [7:0] d);
      @(negedge clk);
      start = s; bus.byte_valid = v; bus.byte_data = d;
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      for (int b = 0; b < 4; b++) begin
         drive(1'b0, 1'b1, w[31-8*b -: 8]);
      end
   endtask

   function automatic logic [31:0] pat(input int w);
      logic [15:0] lo;
      lo = 16'(w);
      return {~lo, lo};
   endfunction

   initial begin
      logic [31:0] wd;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;

`ifndef IM_LOADER_CHECKSUM_EN
      //     r s v data   rdy we addr          wdata         h dn er cnt
      // two-word load
      add(1,0,0,8'h00, 0,0,32'h3000,32'h0,    1,0,0,0);
      add(0,1,0,8'h00, 0,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h02, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h3C, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h01, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h87, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h65, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h34, 1,1,32'h3000,W1,       1,0,0,1);
      add(0,0,1,8'h21, 1,0,32'h3000,W1,       1,0,0,1);
      add(0,0,1,8'h43, 1,0,32'h3000,W1,       1,0,0,1);
      add(0,0,1,8'h21, 1,0,32'h3000,W1,       1,0,0,1);
      add(0,0,0,8'h00, 0,1,32'h3004,W2,       1,0,0,2);
      add(0,0,0,8'h00, 0,0,32'h3004,W2,       0,1,0,2);
      // N = 0: straight to DONE, no write; byte offered in DONE is refused
      add(0,1,1,8'hFF, 0,0,32'h3004,W2,       0,1,0,2);
      add(0,0,1,8'h00, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,0,8'h00, 0,0,32'h3004,W2,       0,1,0,0);
      // N = 4097: error
      add(0,1,0,8'h00, 0,0,32'h3004,W2,       0,1,0,0);
      add(0,0,1,8'h00, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h10, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h01, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'hAA, 0,0,32'h3004,W2,       1,0,1,0);
      add(0,1,0,8'h00, 0,0,32'h3004,W2,       1,0,1,0);
      // restart from ERR, N = 1 with byte_valid toggling every cycle
      add(0,0,1,8'h00, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,0,8'h55, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,0,8'hFF, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,0,8'h00, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h01, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,0,8'h11, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h12, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,0,8'h99, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h34, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,0,8'h00, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h56, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,0,8'h77, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,1,8'h78, 1,0,32'h3004,W2,       1,0,0,0);
      add(0,0,0,8'h00, 0,1,32'h3000,WN,       1,0,0,1);
      add(0,0,0,8'h00, 0,0,32'h3000,WN,       0,1,0,1);
      // reset after two data bytes, then a clean N = 1 load
      add(0,1,0,8'h00, 0,0,32'h3000,WN,       0,1,0,1);
      add(0,0,1,8'h00, 1,0,32'h3000,WN,       1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3000,WN,       1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3000,WN,       1,0,0,0);
      add(0,0,1,8'h02, 1,0,32'h3000,WN,       1,0,0,0);
      add(0,0,1,8'hAB, 1,0,32'h3000,WN,       1,0,0,0);
      add(0,0,1,8'hCD, 1,0,32'h3000,WN,       1,0,0,0);
      add(1,0,0,8'h00, 0,0,32'h3000,32'h0,    1,0,0,0);
      add(0,1,0,8'h00, 0,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h00, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'h01, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'hDE, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'hAD, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'hBE, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,1,8'hEF, 1,0,32'h3000,32'h0,    1,0,0,0);
      add(0,0,0,8'h00, 0,1,32'h3000,WR,       1,0,0,1);
      add(0,0,0,8'h00, 0,0,32'h3000,WR,       0,1,0,1);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset = vecs[i].r; start = vecs[i].s;
         bus.byte_valid = vecs[i].v; bus.byte_data = vecs[i].d;
         #1;
         chk($sformatf("vec%0d", i),
             96'({bus.byte_ready, bus.im_we, bus.im_addr, bus.im_wdata, cpu_hold, done, err, word_cnt}),
             96'({vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold, vecs[i].dn,
                  vecs[i].er, vecs[i].cnt}));
         $display("vec %0d: r=%b s=%b v=%b d=%h we=%b addr=%h wdata=%h cnt=%0d", i, reset, start,
                  bus.byte_valid, bus.byte_data, bus.im_we, bus.im_addr, bus.im_wdata, word_cnt);
      end
      reset = 1'b0;

      // Full-depth load: N = DEPTH, every address/data checked, last slot at 0x6FFC.
      drive(1'b1, 1'b0, 8'h00);
      send(32'd4096);
      for (int w = 0; w < 4096; w++) begin
         wd = pat(w);
         for (int b = 0; b < 4; b++) begin
            drive(1'b0, 1'b1, wd[31-8*b -: 8]);
            if (w > 0 && b == 0)
               chk($sformatf("full_wr%0d", w - 1),
                   96'({bus.im_we, bus.im_addr, bus.im_wdata, word_cnt}),
                   96'({1'b1, 32'h3000 + 32'(4*(w - 1)), pat(w - 1), 13'(w)}));
            if (w > 0 && b == 1)
               chk($sformatf("full_pulse%0d", w - 1), 96'(bus.im_we), 96'(1'b0));
         end
      end
      drive(1'b0, 1'b0, 8'h00);
      chk("full_last", 96'({bus.im_we, bus.im_addr, bus.im_wdata, word_cnt}),
          96'({1'b1, 32'h0000_6FFC, pat(4095), 13'd4096}));
      drive(1'b0, 1'b0, 8'h00);
      chk("full_done", 96'({bus.byte_ready, done, err, cpu_hold}), 96'({1'b0, 1'b1, 1'b0, 1'b0}));
      $display("full-depth load: %0d words", word_cnt);
`else
      // Checksum build: the sum of W1 and W2 modulo 2^32 is 0x7022CA86.
      for (int pass = 0; pass < 2; pass++) begin
         drive(1'b1, 1'b0, 8'h00);
         send(32'd2);
         send(W1);
         send(W2);
         drive(1'b0, 1'b0, 8'h00);
         chk($sformatf("chk%0d_wr", pass), 96'({bus.im_we, bus.im_addr, bus.im_wdata}),
             96'({1'b1, 32'h3004, W2}));
         drive(1'b0, 1'b0, 8'h00);
         chk($sformatf("chk%0d_state", pass), 96'({bus.byte_ready, done, err, cpu_hold}),
             96'({1'b1, 1'b0, 1'b0, 1'b1}));
         send(pass == 0 ? 32'h7022_CA86 : 32'h0000_0000);
         drive(1'b0, 1'b0, 8'h00);
         chk($sformatf("chk%0d_result", pass), 96'({bus.byte_ready, done, err, cpu_hold}),
             pass == 0 ? 96'({1'b0, 1'b1, 1'b0, 1'b0}) : 96'({1'b0, 1'b0, 1'b1, 1'b1}));
         $display("checksum pass %0d: done=%b err=%b", pass, done, err);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
   end
endmodule
